// File: rtl/lcd_timing_driver.sv
// -----------------------------------------------------------------------------
// lcd_timing_driver
//
// Raster timing generator for the 800x480 RGB565 LCD panel. A horizontal
// counter (h_cnt) and a vertical counter (v_cnt) walk the full line/frame
// period. Every panel output is a purely combinational decode of the two
// counters, so none of them is delayed by an extra register stage.
//
// The pixel-pattern stage downstream has a one-cycle registered output.
// pixel_xpos/pixel_ypos are therefore requested one clock ahead of the
// active window (data_req), and the returned pixel_data lines up with lcd_de.
//
// Request timing: data_req is high for exactly one clock before each lcd_de
// clock. While data_req is high, pixel_xpos/pixel_ypos carry the coordinate
// that the pattern stage must register. That value comes back on pixel_data
// during the following lcd_de clock. There is no back-pressure: the request
// stream is fixed by the raster and cannot be stalled.
//
// Ports:
//   lcd_clk      in   pixel clock, all logic on the rising edge
//   sys_rst_n    in   asynchronous active-low reset
//   pixel_data   in   RGB565 returned by the pattern stage (1 cycle latency)
//   pixel_xpos   out  requested column 0..H_DISP-1 (0 when not requesting)
//   pixel_ypos   out  requested row    0..V_DISP-1 (0 when not requesting)
//   data_req     out  coordinate valid, one clock ahead of lcd_de
//   lcd_hs       out  horizontal sync, active low
//   lcd_vs       out  vertical sync, active low
//   lcd_de       out  data enable, active high
//   lcd_rgb      out  panel pixel bus, forced to 0 outside lcd_de
//   frame_start  out  one-clock pulse at h_cnt==0, v_cnt==0
// -----------------------------------------------------------------------------
module lcd_timing_driver #(
  parameter logic [10:0] H_SYNC  = 11'd128,
  parameter logic [10:0] H_BACK  = 11'd88,
  parameter logic [10:0] H_DISP  = 11'd800,
  parameter logic [10:0] H_FRONT = 11'd40,
  parameter logic [10:0] H_TOTAL = 11'd1056,
  parameter logic [10:0] V_SYNC  = 11'd2,
  parameter logic [10:0] V_BACK  = 11'd33,
  parameter logic [10:0] V_DISP  = 11'd480,
  parameter logic [10:0] V_FRONT = 11'd10,
  parameter logic [10:0] V_TOTAL = 11'd525
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_start
);

  // First active column / line, measured from the start of the sync pulse.
  localparam logic [10:0] HA = H_SYNC + H_BACK;
  localparam logic [10:0] VA = V_SYNC + V_BACK;

  // Request window is the active window shifted one clock earlier.
  localparam logic [10:0] HR_START = HA - 11'd1;
  localparam logic [10:0] HR_END   = HA + H_DISP - 11'd1;
  localparam logic [10:0] HA_END   = HA + H_DISP;
  localparam logic [10:0] VA_END   = VA + V_DISP;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        v_active;
  logic        h_last;

  assign h_last = (h_cnt == H_TOTAL - 11'd1);

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else if (h_last) begin
      h_cnt <= 11'd0;
      if (v_cnt == V_TOTAL - 11'd1) begin
        v_cnt <= 11'd0;
      end else begin
        v_cnt <= v_cnt + 11'd1;
      end
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign v_active = (v_cnt >= VA) && (v_cnt < VA_END);

  assign lcd_hs   = (h_cnt >= H_SYNC);
  assign lcd_vs   = (v_cnt >= V_SYNC);
  assign lcd_de   = v_active && (h_cnt >= HA) && (h_cnt < HA_END);
  assign data_req = v_active && (h_cnt >= HR_START) && (h_cnt < HR_END);

  // Subtractions are only selected inside the request window, where
  // h_cnt >= HA-1 and v_cnt >= VA, so neither can underflow.
  assign pixel_xpos = data_req ? (h_cnt - HR_START) : 11'd0;
  assign pixel_ypos = data_req ? (v_cnt - VA) : 11'd0;

  assign lcd_rgb = lcd_de ? pixel_data : 16'd0;

  // The counters sit at 0,0 throughout reset, so the pulse is qualified
  // with the reset input to keep it low until the first running clock.
  assign frame_start = sys_rst_n && (h_cnt == 11'd0) && (v_cnt == 11'd0);

endmodule

// File: tb/tb_lcd_timing_driver.sv
module tb_lcd_timing_driver;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  logic sys_rst_n;
  logic s_rst_n;

  // Full-size panel instance
  logic [15:0] pixel_data;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        data_req, lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [15:0] lcd_rgb;

  // Miniature instance (17x10 clocks per frame) for frame-level properties
  logic [15:0] s_pixel_data;
  logic [10:0] s_pixel_xpos, s_pixel_ypos;
  logic        s_data_req, s_lcd_hs, s_lcd_vs, s_lcd_de, s_frame_start;
  logic [15:0] s_lcd_rgb;

  lcd_timing_driver dut (
    .lcd_clk     (lcd_clk),
    .sys_rst_n   (sys_rst_n),
    .pixel_data  (pixel_data),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .data_req    (data_req),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_rgb     (lcd_rgb),
    .frame_start (frame_start)
  );

  lcd_timing_driver #(
    .H_SYNC(11'd4), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2), .H_TOTAL(11'd17),
    .V_SYNC(11'd2), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd2), .V_TOTAL(11'd10)
  ) dut_small (
    .lcd_clk     (lcd_clk),
    .sys_rst_n   (s_rst_n),
    .pixel_data  (s_pixel_data),
    .pixel_xpos  (s_pixel_xpos),
    .pixel_ypos  (s_pixel_ypos),
    .data_req    (s_data_req),
    .lcd_hs      (s_lcd_hs),
    .lcd_vs      (s_lcd_vs),
    .lcd_de      (s_lcd_de),
    .lcd_rgb     (s_lcd_rgb),
    .frame_start (s_frame_start)
  );

  // Pattern stage: one-cycle register of the requested coordinate. Outside a
  // request it returns all ones, which must never reach the panel bus.
  always @(posedge lcd_clk) begin
    pixel_data   <= data_req   ? {pixel_xpos[7:0], pixel_ypos[7:0]}     : 16'hFFFF;
    s_pixel_data <= s_data_req ? {s_pixel_xpos[7:0], s_pixel_ypos[7:0]} : 16'hFFFF;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference raster model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] s_exp_q[$];

  int h_m = 0, v_m = 0;
  int sh_m = 0, sv_m = 0;
  bit big_rst = 1'b1;
  bit small_rst = 1'b1;

  int de_line = 0, hs_low = 0;
  int s_len = 0, s_de = 0, s_vs_low = 0;
  bit s_seen = 1'b0;

  // Returns {frame_start, data_req, lcd_de, lcd_hs, lcd_vs, xpos[10:0], ypos[10:0]}
  function automatic logic [26:0] model(int h, int v, bit in_rst,
                                        int hs, int hb, int hd,
                                        int vs, int vb, int vd);
    int ha, va;
    bit vok, de, dr;
    logic [10:0] x, y;
    ha  = hs + hb;
    va  = vs + vb;
    vok = (v >= va) && (v < va + vd);
    de  = vok && (h >= ha) && (h < ha + hd);
    dr  = vok && (h >= ha - 1) && (h < ha + hd - 1);
    x   = dr ? 11'(h - ha + 1) : 11'd0;
    y   = dr ? 11'(v - va) : 11'd0;
    return {(!in_rst && h == 0 && v == 0), dr, de, (h >= hs), (v >= vs), x, y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h h=%0d v=%0d", tag, got, exp, h_m, v_m);
    end
  endtask

  // One clock: sample at the falling edge, compare, then advance the models
  // to the state the next rising edge will produce.
  task automatic step();
    logic [26:0] e, es;
    logic [15:0] w;
    @(negedge lcd_clk);

    // ---- full-size instance ----
    e = model(h_m, v_m, big_rst, 128, 88, 800, 2, 33, 480);
    chk("big_out", {5'd0, frame_start, data_req, lcd_de, lcd_hs, lcd_vs, pixel_xpos, pixel_ypos},
        {5'd0, e});
    if (lcd_de) begin
      w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
      chk("big_rgb", {16'd0, lcd_rgb}, {16'd0, w});
    end else begin
      chk("big_blank_rgb", {16'd0, lcd_rgb}, 32'd0);
    end
    if (e[25]) exp_q.push_back({e[18:11], e[7:0]});

    if (big_rst) begin
      de_line = 0;
      hs_low  = 0;
    end else begin
      de_line += int'(lcd_de);
      hs_low  += int'(!lcd_hs);
      if (h_m == 1055) begin
        chk("hs_width", hs_low, 128);
        if (v_m >= 35 && v_m < 515) chk("de_per_line", de_line, 800);
        de_line = 0;
        hs_low  = 0;
      end
    end

    // ---- miniature instance ----
    es = model(sh_m, sv_m, small_rst, 4, 3, 8, 2, 2, 4);
    chk("small_out", {5'd0, s_frame_start, s_data_req, s_lcd_de, s_lcd_hs, s_lcd_vs,
                      s_pixel_xpos, s_pixel_ypos}, {5'd0, es});
    if (s_lcd_de) begin
      w = (s_exp_q.size() != 0) ? s_exp_q.pop_front() : 16'hDEAD;
      chk("small_rgb", {16'd0, s_lcd_rgb}, {16'd0, w});
    end else begin
      chk("small_blank_rgb", {16'd0, s_lcd_rgb}, 32'd0);
    end
    if (es[25]) s_exp_q.push_back({es[18:11], es[7:0]});

    if (s_frame_start) begin
      if (s_seen) begin
        chk("s_frame_len", s_len, 170);
        chk("s_de_frame", s_de, 32);
        chk("s_vs_low", s_vs_low, 34);
      end
      s_seen   = 1'b1;
      s_len    = 0;
      s_de     = 0;
      s_vs_low = 0;
    end
    s_len    += 1;
    s_de     += int'(s_lcd_de);
    s_vs_low += int'(!s_lcd_vs);

    // ---- advance reference counters ----
    if (!big_rst) begin
      h_m++;
      if (h_m == 1056) begin
        h_m = 0;
        v_m = (v_m + 1) % 525;
      end
    end
    if (!small_rst) begin
      sh_m++;
      if (sh_m == 17) begin
        sh_m = 0;
        sv_m = (sv_m + 1) % 10;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    sys_rst_n = 1'b0;
    s_rst_n   = 1'b0;

    // Reset held: everything low, including syncs and frame_start.
    repeat (5) step();

    // Release just after a rising edge so the 0,0 state is visible for a
    // full clock and frame_start is observed on the first clock.
    @(posedge lcd_clk);
    #1;
    sys_rst_n = 1'b1;
    s_rst_n   = 1'b1;
    big_rst   = 1'b0;
    small_rst = 1'b0;

    // Blanking lines, first active lines (35, 36) and into line 36 mid-way.
    while (!(v_m == 36 && h_m == 500)) step();

    // Asynchronous reset mid-line: outputs must clear without a clock edge.
    @(posedge lcd_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_out", {5'd0, frame_start, data_req, lcd_de, lcd_hs, lcd_vs, pixel_xpos, pixel_ypos},
        32'd0);
    chk("async_rst_rgb", {16'd0, lcd_rgb}, 32'd0);
    big_rst = 1'b1;
    h_m = 0;
    v_m = 0;
    exp_q.delete();

    repeat (3) step();

    @(posedge lcd_clk);
    #1;
    sys_rst_n = 1'b1;
    big_rst   = 1'b0;

    // Restart from 0,0: frame_start, vsync low for two full lines, clean lines.
    repeat (1056 * 2 + 300) step();

    chk("big_q_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_timing_driver.md
Name: lcd_timing_driver

Overview:
- Generates the raster timing for the 800x480 RGB565 LCD panel.
- Produces the pixel coordinates consumed by the pixel-pattern stage one cycle ahead of the active-video window, so that stage's 1-cycle registered output lines up with lcd_de.
- Gates the returned pixel_data onto the panel bus and emits hsync, vsync, DE and a frame-start strobe.
- Sits directly upstream and downstream of the pattern generator: it feeds pixel_xpos/pixel_ypos and consumes pixel_data.

Parameters:
H_SYNC, 11'd128, hsync pulse width (clocks)
H_BACK, 11'd88, horizontal back porch
H_DISP, 11'd800, active pixels per line
H_FRONT, 11'd40, horizontal front porch
H_TOTAL, 11'd1056, line period = sum of the four above
V_SYNC, 11'd2, vsync pulse width (lines)
V_BACK, 11'd33, vertical back porch
V_DISP, 11'd480, active lines per frame
V_FRONT, 11'd10, vertical front porch
V_TOTAL, 11'd525, frame period in lines

Ports:
lcd_clk  input  1  pixel clock; all logic rising-edge
sys_rst_n  input  1  asynchronous, active-low reset
pixel_data  input  16  RGB565 from the pattern stage, registered there one cycle after pixel_xpos/pixel_ypos
pixel_xpos  output  11  column being requested, 0..H_DISP-1
pixel_ypos  output  11  row being requested, 0..V_DISP-1
data_req  output  1  coordinate-valid; high exactly one clock before each lcd_de cycle
lcd_hs  output  1  horizontal sync, active low
lcd_vs  output  1  vertical sync, active low
lcd_de  output  1  data enable, active high
lcd_rgb  output  16  panel pixel bus
frame_start  output  1  one-clock pulse at the first clock of each frame

Behaviour:
- Clock and reset: one clock (lcd_clk). Reset is asynchronous and active-low (sys_rst_n). Reset clears all state regardless of lcd_clk.
- Counters: h_cnt, 11 bits, counts 0..H_TOTAL-1 and wraps to 0. v_cnt, 11 bits, increments only on the h_cnt wrap (h_cnt==H_TOTAL-1). v_cnt wraps to 0 when h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1. Both reset to 0.
- Windows: HA = H_SYNC+H_BACK = 216. VA = V_SYNC+V_BACK = 35.
- Output decode: all outputs are combinational decodes of the current h_cnt/v_cnt. None has an extra register stage.
- lcd_hs = 0 when h_cnt < H_SYNC, else 1.
- lcd_vs = 0 when v_cnt < V_SYNC, else 1.
- Sync values in reset: counters are held at 0, so lcd_hs=0 and lcd_vs=0. This is intended.
- lcd_de = 1 when HA <= h_cnt < HA+H_DISP and VA <= v_cnt < VA+V_DISP.
- data_req = 1 when HA-1 <= h_cnt < HA+H_DISP-1, in the same v window as lcd_de.
- pixel_xpos = h_cnt-(HA-1) when data_req is high, else 0.
- pixel_ypos = v_cnt-VA when data_req is high, else 0.
- Coordinate range: when data_req is high, pixel_xpos never exceeds H_DISP-1 and pixel_ypos never exceeds V_DISP-1. The subtractions must not underflow.
- lcd_rgb = pixel_data when lcd_de is high, else 16'd0. No blanking-period data leaks onto the bus.
- frame_start = 1 only when h_cnt==0 and v_cnt==0. It stays low in reset.
- Reset mid-frame: counters return to 0 immediately. The first frame after release is complete and frame_start fires on the first clock after release. No partial-line DE occurs.
- Latency contract: coordinate (x,y) is presented at clock t. The pattern stage registers its pixel_data at t+1. That pixel is driven on lcd_rgb during the lcd_de cycle at t+1.
- Line and frame size: 800 DE cycles per active line, 480 active lines per frame, 1056x525 clocks per frame.
- Parameter changes: all thresholds derive from the parameters. No hard-coded 216/35 in the RTL.

Test Plan:
- Reset held, then released: lcd_hs=0, lcd_vs=0, lcd_de=0, data_req=0, lcd_rgb=0, pixel_xpos=0, pixel_ypos=0 throughout reset. frame_start=1 on the first clock after release.
- Run to v_cnt=35: data_req rises at h_cnt=215 with pixel_xpos=0 and pixel_ypos=0. lcd_de rises at h_cnt=216. The last data_req has pixel_xpos=799 at h_cnt=1014. lcd_de falls after h_cnt=1015.
- Pattern stage modelled as a 1-cycle register of {pixel_xpos[7:0],pixel_ypos[7:0]}: every lcd_de cycle carries the coordinates of its own position. lcd_rgb=0 in all blanking cycles even when pixel_data is driven to 16'hFFFF.
- Count lcd_de per frame: 384000 exactly. Count hsync low periods per frame: 525, each 128 clocks wide. Vsync low period: 2x1056 clocks.
- Frame wrap: at h_cnt=1055, v_cnt=524, the next clock gives h_cnt=0, v_cnt=0 and frame_start=1. Frame period measures 554400 clocks.
- Assert sys_rst_n low at h_cnt=500, v_cnt=200 for 3 clocks: all outputs go to reset values asynchronously. After release, the counters restart from 0,0 and a full frame follows.
